reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  Circular reorder buffer between issue, the CDB and the register file. Allocates a
//  tag per issued instruction, captures results from the CDB and retires entries in
//  program order. Each retirement drives the regfile commit port (write/addr/rob_pos/data).
//  On a mispredicted branch at head it raises a flush to the whole core.
// PARAMETERS
//  ROB_DEPTH  16  number of entries (power of two)
//  ROB_AW     4   tag width, log2(ROB_DEPTH)
//  DATA_W     32  data/PC width
//  REG_AW     5   architectural register index width
// PORTS
//  clk_in                 in   1       clock, rising edge
//  rst_n_in               in   1       asynchronous active-low reset
//  rdy_in                 in   1       global stall; low = hold all state
//  transmit_from_issue    in   1       allocate request
//  rd_from_issue          in   REG_AW  destination register (0 = no write)
//  is_branch_from_issue   in   1       entry is a branch/jump
//  rob_pos_to_issue       out  ROB_AW  tag allocated this cycle (= tail)
//  full_to_issue          out  1       no free entry
//  cdb_valid_in           in   1       result broadcast valid
//  cdb_rob_pos_in         in   ROB_AW  tag of result
//  cdb_data_in            in   DATA_W  result value
//  cdb_mispredict_in      in   1       branch outcome mispredicted
//  cdb_target_in          in   DATA_W  correct branch target
//  write_to_regfile       out  1       commit pulse
//  addr_to_regfile        out  REG_AW  committed rd
//  rob_pos_to_regfile     out  ROB_AW  committed tag
//  data_to_regfile        out  DATA_W  committed value
//  flush_to_all           out  1       one-cycle flush pulse
//  pc_to_fetch            out  DATA_W  redirect PC, valid with flush_to_all
// BEHAVIOUR
//  - Reset: head=tail=count=0, all entry valid/ready bits 0, every output 0 except
//    full_to_issue=0, rob_pos_to_issue=0.
//  - rdy_in low: no state changes; commit/flush outputs held at 0.
//  - Entry: valid, ready, rd, is_branch, data, mispredict, target.
//  - Issue: accepted when transmit_from_issue && count<ROB_DEPTH && !flush_to_all; writes
//    entry[tail] (ready=0), tail+1 mod ROB_DEPTH. rob_pos_to_issue = tail, combinational.
//  - full_to_issue = (count==ROB_DEPTH), from registered count; commit freeing a slot
//    the same cycle does not admit an issue that cycle.
//  - CDB: if entry[cdb_rob_pos_in].valid, set ready, latch data/mispredict/target; CDB on
//    an invalid slot is ignored. A result at head commits no earlier than next edge.
//  - Commit: at most one per cycle when entry[head].valid && ready. Outputs registered:
//    pulse on the cycle after the retire edge. write_to_regfile=1 only when rd!=0;
//    addr/rob_pos/data carry the retired entry. head+1, count-1, entry invalidated.
//  - Issue+commit same edge: count unchanged, both pointers advance.
//  - Flush: retiring branch with mispredict=1 also writes rd (link) and registers
//    flush_to_all=1, pc_to_fetch=target. During the flush cycle issue and CDB are
//    ignored; at its edge all valid bits clear, head=tail=count=0. No commit while
//    flush_to_all=1.
//  - Pointers wrap at ROB_DEPTH; count is ROB_AW+1 bits, never exceeds ROB_DEPTH.
//  - Reset asserted mid-operation clears immediately regardless of rdy_in/clock.
// CONFIGURATION
//  ROB_PERF_EN defined: adds outputs commit_cnt_out[31:0] (retired entries) and
//    flush_cnt_out[31:0] (flushes), reset to 0, wrap at 2^32, frozen when rdy_in low.
//  ROB_PERF_EN undefined: ports and counters absent; rest unchanged.
// TESTING
//  1 Reset: rst_n_in=0 mid-run -> all outputs 0, count=0; first issue gets tag 0.
//  2 Issue rd=5, CDB tag 0 data 0x1234 -> 2 cycles later write_to_regfile=1,
//    addr=5, rob_pos=0, data=0x1234 for exactly one cycle.
//  3 Issue 16 entries no CDB -> full_to_issue=1, 17th issue ignored, tail stays 0;
//    CDB tag 0 -> commit; next cycle full=0, issue gets tag 0 (wrap).
//  4 Out-of-order CDB: tags 2,1,0 complete in that order -> commits in order 0,1,2,
//    one per cycle.
//  5 Branch tag 3 rd=1 mispredict target 0x80 with tags 4-6 in flight -> commit rd=1,
//    flush_to_all=1, pc_to_fetch=0x80; next cycle count=0, next issue gets tag 0.
//  6 rdy_in=0 for 3 cycles with head ready -> no commit pulse; commit on rdy_in=1.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at issue, captures CDB results and retires in order.
// Optional performance counters (commit_cnt_out, flush_cnt_out) are built when ROB_PERF_EN is defined.
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB_AW    = 4,
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              transmit_from_issue,
  input  logic [REG_AW-1:0] rd_from_issue,
  input  logic              is_branch_from_issue,
  output logic [ROB_AW-1:0] rob_pos_to_issue,
  output logic              full_to_issue,
  input  logic              cdb_valid_in,
  input  logic [ROB_AW-1:0] cdb_rob_pos_in,
  input  logic [DATA_W-1:0] cdb_data_in,
  input  logic              cdb_mispredict_in,
  input  logic [DATA_W-1:0] cdb_target_in,
  output logic              write_to_regfile,
  output logic [REG_AW-1:0] addr_to_regfile,
  output logic [ROB_AW-1:0] rob_pos_to_regfile,
  output logic [DATA_W-1:0] data_to_regfile,
  output logic              flush_to_all,
  output logic [DATA_W-1:0] pc_to_fetch
`ifdef ROB_PERF_EN
  ,
  output logic [31:0]       commit_cnt_out,
  output logic [31:0]       flush_cnt_out
`endif
);

  localparam int CW = ROB_AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(ROB_DEPTH);

  logic [ROB_DEPTH-1:0] valid_q, valid_d;
  logic [ROB_DEPTH-1:0] ready_q, ready_d;
  logic [ROB_DEPTH-1:0] br_q, br_d;
  logic [ROB_DEPTH-1:0] mis_q, mis_d;
  logic [REG_AW-1:0]    rd_q   [ROB_DEPTH];
  logic [REG_AW-1:0]    rd_d   [ROB_DEPTH];
  logic [DATA_W-1:0]    data_q [ROB_DEPTH];
  logic [DATA_W-1:0]    data_d [ROB_DEPTH];
  logic [DATA_W-1:0]    tgt_q  [ROB_DEPTH];
  logic [DATA_W-1:0]    tgt_d  [ROB_DEPTH];

  logic [ROB_AW-1:0] head_q, head_d;
  logic [ROB_AW-1:0] tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic              write_q, write_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [ROB_AW-1:0] pos_q, pos_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              flush_q, flush_d;
  logic [DATA_W-1:0] pc_q, pc_d;

  logic issue_ok;
  logic cdb_ok;
  logic commit_ok;
  logic do_flush;

  // Issue handshake: transmit_from_issue is a request that is accepted on an edge where
  // rdy_in=1, full_to_issue=0 and flush_to_all=0; the accepted entry gets tag rob_pos_to_issue.
  // Commit and flush outputs are one-cycle pulses with no back-pressure.
  assign issue_ok  = rdy_in && transmit_from_issue && (count_q != FULL_CNT) && !flush_q;
  assign cdb_ok    = rdy_in && cdb_valid_in && !flush_q && valid_q[cdb_rob_pos_in];
  assign commit_ok = rdy_in && !flush_q && valid_q[head_q] && ready_q[head_q];
  assign do_flush  = commit_ok && br_q[head_q] && mis_q[head_q];

  always_comb begin
    valid_d = valid_q;
    ready_d = ready_q;
    br_d    = br_q;
    mis_d   = mis_q;
    rd_d    = rd_q;
    data_d  = data_q;
    tgt_d   = tgt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    write_d = 1'b0;
    flush_d = 1'b0;
    addr_d  = addr_q;
    pos_d   = pos_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;

    if (cdb_ok) begin
      ready_d[cdb_rob_pos_in] = 1'b1;
      data_d[cdb_rob_pos_in]  = cdb_data_in;
      mis_d[cdb_rob_pos_in]   = cdb_mispredict_in;
      tgt_d[cdb_rob_pos_in]   = cdb_target_in;
    end

    // tail never equals a committing head here: that needs count 0 (no commit) or full (no issue)
    if (issue_ok) begin
      valid_d[tail_q] = 1'b1;
      ready_d[tail_q] = 1'b0;
      br_d[tail_q]    = is_branch_from_issue;
      mis_d[tail_q]   = 1'b0;
      rd_d[tail_q]    = rd_from_issue;
      tail_d          = tail_q + ROB_AW'(1);
    end

    if (commit_ok) begin
      write_d         = (rd_q[head_q] != '0);
      addr_d          = rd_q[head_q];
      pos_d           = head_q;
      wdata_d         = data_q[head_q];
      valid_d[head_q] = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + ROB_AW'(1);
    end

    count_d = count_q + CW'(issue_ok) - CW'(commit_ok);

    // The squash is applied on the retire edge, so the flush cycle already sees an empty buffer.
    if (do_flush) begin
      flush_d = 1'b1;
      pc_d    = tgt_q[head_q];
      valid_d = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q <= '0;
      ready_q <= '0;
      br_q    <= '0;
      mis_q   <= '0;
      rd_q    <= '{default: '0};
      data_q  <= '{default: '0};
      tgt_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      pos_q   <= '0;
      wdata_q <= '0;
      flush_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      br_q    <= br_d;
      mis_q   <= mis_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      tgt_q   <= tgt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      pos_q   <= pos_d;
      wdata_q <= wdata_d;
      flush_q <= flush_d;
      pc_q    <= pc_d;
    end
  end

  assign rob_pos_to_issue   = tail_q;
  assign full_to_issue      = (count_q == FULL_CNT);
  assign write_to_regfile   = write_q;
  assign addr_to_regfile    = addr_q;
  assign rob_pos_to_regfile = pos_q;
  assign data_to_regfile    = wdata_q;
  assign flush_to_all       = flush_q;
  assign pc_to_fetch        = pc_q;

`ifdef ROB_PERF_EN
  logic [31:0] commit_cnt_q, commit_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    commit_cnt_d = commit_cnt_q + 32'(commit_ok);
    flush_cnt_d  = flush_cnt_q + 32'(do_flush);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      commit_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      commit_cnt_q <= commit_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign commit_cnt_out = commit_cnt_q;
  assign flush_cnt_out  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: scoreboard of expected commits plus per-scenario checks.
module tb_reorder_buffer;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_AW    = 4;
  localparam int DATA_W    = 32;
  localparam int REG_AW    = 5;
  localparam int W         = REG_AW + ROB_AW + DATA_W;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              rdy_in;
  logic              transmit_from_issue;
  logic [REG_AW-1:0] rd_from_issue;
  logic              is_branch_from_issue;
  logic [ROB_AW-1:0] rob_pos_to_issue;
  logic              full_to_issue;
  logic              cdb_valid_in;
  logic [ROB_AW-1:0] cdb_rob_pos_in;
  logic [DATA_W-1:0] cdb_data_in;
  logic              cdb_mispredict_in;
  logic [DATA_W-1:0] cdb_target_in;
  logic              write_to_regfile;
  logic [REG_AW-1:0] addr_to_regfile;
  logic [ROB_AW-1:0] rob_pos_to_regfile;
  logic [DATA_W-1:0] data_to_regfile;
  logic              flush_to_all;
  logic [DATA_W-1:0] pc_to_fetch;
`ifdef ROB_PERF_EN
  logic [31:0]       commit_cnt_out;
  logic [31:0]       flush_cnt_out;
`endif

  reorder_buffer #(
    .ROB_DEPTH(ROB_DEPTH), .ROB_AW(ROB_AW), .DATA_W(DATA_W), .REG_AW(REG_AW)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .rdy_in(rdy_in),
    .transmit_from_issue(transmit_from_issue),
    .rd_from_issue(rd_from_issue),
    .is_branch_from_issue(is_branch_from_issue),
    .rob_pos_to_issue(rob_pos_to_issue),
    .full_to_issue(full_to_issue),
    .cdb_valid_in(cdb_valid_in),
    .cdb_rob_pos_in(cdb_rob_pos_in),
    .cdb_data_in(cdb_data_in),
    .cdb_mispredict_in(cdb_mispredict_in),
    .cdb_target_in(cdb_target_in),
    .write_to_regfile(write_to_regfile),
    .addr_to_regfile(addr_to_regfile),
    .rob_pos_to_regfile(rob_pos_to_regfile),
    .data_to_regfile(data_to_regfile),
    .flush_to_all(flush_to_all),
    .pc_to_fetch(pc_to_fetch)
`ifdef ROB_PERF_EN
    ,
    .commit_cnt_out(commit_cnt_out),
    .flush_cnt_out(flush_cnt_out)
`endif
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  logic [W-1:0]      exp_q[$];
  logic [ROB_AW-1:0] m_tail;
  logic [DATA_W-1:0] m_data [ROB_DEPTH];

  logic              s_write;
  logic              s_flush;
  logic [REG_AW-1:0] s_addr;
  logic [ROB_AW-1:0] s_pos;
  logic [DATA_W-1:0] s_data;
  logic [DATA_W-1:0] s_pc;

  // One cycle: sample outputs mid-cycle, score any commit pulse, then step past the next edge.
  task automatic tick();
    logic [W-1:0] e;
    @(negedge clk_in);
    s_write = write_to_regfile;
    s_flush = flush_to_all;
    s_addr  = addr_to_regfile;
    s_pos   = rob_pos_to_regfile;
    s_data  = data_to_regfile;
    s_pc    = pc_to_fetch;
    if (rst_n_in && s_write) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL commit_unexpected: got addr=%0d pos=%0d data=%h, expected no commit",
                 s_addr, s_pos, s_data);
      end else begin
        e = exp_q.pop_front();
        if ({s_addr, s_pos, s_data} !== e) begin
          bad++;
          $display("FAIL commit_entry: got %h want %h", {s_addr, s_pos, s_data}, e);
        end
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  // driver tasks
  task automatic drive_issue(input logic [REG_AW-1:0] rd, input logic br,
                             input logic [DATA_W-1:0] d, input bit accept, input bit push);
    transmit_from_issue  = 1'b1;
    rd_from_issue        = rd;
    is_branch_from_issue = br;
    total++;
    if (rob_pos_to_issue !== m_tail) begin
      bad++;
      $display("FAIL issue_tag: got %0d want %0d", rob_pos_to_issue, m_tail);
    end
    total++;
    if (full_to_issue !== !accept) begin
      bad++;
      $display("FAIL issue_full: got %0b want %0b", full_to_issue, !accept);
    end
    tick();
    transmit_from_issue  = 1'b0;
    rd_from_issue        = '0;
    is_branch_from_issue = 1'b0;
    if (accept) begin
      m_data[m_tail] = d;
      if (push) exp_q.push_back({rd, m_tail, d});
      m_tail = m_tail + ROB_AW'(1);
    end
  endtask

  task automatic drive_cdb(input logic [ROB_AW-1:0] tag, input logic mis,
                           input logic [DATA_W-1:0] tgt);
    cdb_valid_in      = 1'b1;
    cdb_rob_pos_in    = tag;
    cdb_data_in       = m_data[tag];
    cdb_mispredict_in = mis;
    cdb_target_in     = tgt;
    tick();
    cdb_valid_in      = 1'b0;
    cdb_mispredict_in = 1'b0;
    cdb_data_in       = '0;
    cdb_target_in     = '0;
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending commits want 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    tick();
    tick();
    rst_n_in = 1'b1;
    m_tail   = '0;
    exp_q.delete();
  endtask

  // scenarios
  task automatic test_reset();
    rst_n_in = 1'b0;
    tick();
    tick();
    total++;
    if ({write_to_regfile, addr_to_regfile, rob_pos_to_regfile, data_to_regfile,
         flush_to_all, pc_to_fetch, full_to_issue, rob_pos_to_issue} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got nonzero output, tag=%0d full=%0b", rob_pos_to_issue,
               full_to_issue);
    end
    rst_n_in = 1'b1;
    m_tail   = '0;
    drive_issue(5'd7, 1'b0, $urandom(), 1'b1, 1'b1);
    drive_issue(5'd9, 1'b0, $urandom(), 1'b1, 1'b0);
    drive_cdb(4'd0, 1'b0, '0);
    tick();
    total++;
    if (write_to_regfile !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_commit: got %0b want 1", write_to_regfile);
    end
    #2;
    rst_n_in = 1'b0;
    #1;
    total++;
    if ({write_to_regfile, addr_to_regfile, rob_pos_to_regfile, data_to_regfile,
         flush_to_all, pc_to_fetch, full_to_issue, rob_pos_to_issue} !== '0) begin
      bad++;
      $display("FAIL midrun_reset_outputs: got write=%0b addr=%0d data=%h tag=%0d want all 0",
               write_to_regfile, addr_to_regfile, data_to_regfile, rob_pos_to_issue);
    end
    exp_q.delete();
    m_tail = '0;
    tick();
    tick();
    rst_n_in = 1'b1;
    drive_issue(5'd3, 1'b0, $urandom(), 1'b1, 1'b1);
    drive_cdb(4'd0, 1'b0, '0);
    wait_empty(10);
  endtask

  task automatic test_single_commit();
    do_reset();
    drive_issue(5'd5, 1'b0, 32'h1234, 1'b1, 1'b1);
    drive_cdb(4'd0, 1'b0, '0);
    tick();
    total++;
    if (s_write !== 1'b0) begin
      bad++;
      $display("FAIL single_early: got write=%0b want 0", s_write);
    end
    tick();
    total++;
    if ({s_write, s_addr, s_pos, s_data} !== {1'b1, 5'd5, 4'd0, 32'h1234}) begin
      bad++;
      $display("FAIL single_commit: got w=%0b addr=%0d pos=%0d data=%h want w=1 addr=5 pos=0 data=1234",
               s_write, s_addr, s_pos, s_data);
    end
    tick();
    total++;
    if (s_write !== 1'b0) begin
      bad++;
      $display("FAIL single_pulse_width: got write=%0b want 0", s_write);
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < ROB_DEPTH; i++)
      drive_issue(5'($urandom_range(1, 31)), 1'b0, $urandom(), 1'b1, 1'b1);
    drive_issue(5'd4, 1'b0, $urandom(), 1'b0, 1'b0);
    total++;
    if ({full_to_issue, rob_pos_to_issue} !== {1'b1, 4'd0}) begin
      bad++;
      $display("FAIL full_hold: got full=%0b tag=%0d want full=1 tag=0", full_to_issue,
               rob_pos_to_issue);
    end
    drive_cdb(4'd0, 1'b0, '0);
    drive_issue(5'd6, 1'b0, $urandom(), 1'b0, 1'b0);
    drive_issue(5'($urandom_range(1, 31)), 1'b0, $urandom(), 1'b1, 1'b1);
    for (int i = 1; i < ROB_DEPTH; i++) drive_cdb(ROB_AW'(i), 1'b0, '0);
    drive_cdb(4'd0, 1'b0, '0);
    wait_empty(40);
  endtask

  task automatic test_out_of_order();
    logic [ROB_AW-1:0] base;
    bit want;
    base = m_tail;
    for (int i = 0; i < 3; i++)
      drive_issue(5'($urandom_range(1, 31)), 1'b0, $urandom(), 1'b1, 1'b1);
    drive_cdb(ROB_AW'(base + 2), 1'b0, '0);
    drive_cdb(ROB_AW'(base + 1), 1'b0, '0);
    drive_cdb(base, 1'b0, '0);
    for (int k = 0; k < 5; k++) begin
      tick();
      want = (k >= 1 && k <= 3);
      total++;
      if (s_write !== want || (want && s_pos !== ROB_AW'(base + k - 1))) begin
        bad++;
        $display("FAIL ooo_cycle%0d: got write=%0b pos=%0d want write=%0b pos=%0d", k, s_write,
                 s_pos, want, ROB_AW'(base + k - 1));
      end
    end
  endtask

  task automatic test_flush();
    bit found;
    do_reset();
    for (int i = 0; i < 3; i++)
      drive_issue(5'($urandom_range(1, 31)), 1'b0, $urandom(), 1'b1, 1'b1);
    drive_issue(5'd1, 1'b1, $urandom(), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      drive_issue(5'($urandom_range(1, 31)), 1'b0, $urandom(), 1'b1, 1'b0);
    drive_cdb(4'd0, 1'b0, '0);
    drive_cdb(4'd1, 1'b0, '0);
    drive_cdb(4'd2, 1'b0, '0);
    drive_cdb(4'd5, 1'b0, '0);
    drive_cdb(4'd3, 1'b1, 32'h80);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = s_flush;
    end
    total++;
    if (!found || {s_pc, s_write, s_addr, s_pos} !== {32'h80, 1'b1, 5'd1, 4'd3}) begin
      bad++;
      $display("FAIL flush_commit: got flush=%0b pc=%h w=%0b addr=%0d pos=%0d want 1 80 1 1 3",
               found, s_pc, s_write, s_addr, s_pos);
    end
    total++;
    if ({full_to_issue, rob_pos_to_issue} !== {1'b0, 4'd0}) begin
      bad++;
      $display("FAIL flush_ptrs: got full=%0b tag=%0d want 0 0", full_to_issue, rob_pos_to_issue);
    end
    tick();
    total++;
    if ({s_flush, s_write} !== 2'b00) begin
      bad++;
      $display("FAIL flush_pulse: got flush=%0b write=%0b want 0 0", s_flush, s_write);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL flush_retired: got %0d unretired want 0", exp_q.size());
    end
    m_tail = '0;
    drive_issue(5'($urandom_range(1, 31)), 1'b0, $urandom(), 1'b1, 1'b1);
    drive_cdb(4'd0, 1'b0, '0);
    wait_empty(10);
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_stall();
    logic [ROB_AW-1:0] base;
    base = m_tail;
    drive_issue(5'($urandom_range(1, 31)), 1'b0, $urandom(), 1'b1, 1'b1);
    drive_cdb(base, 1'b0, '0);
    rdy_in              = 1'b0;
    transmit_from_issue = 1'b1;
    rd_from_issue       = 5'd3;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (s_write !== 1'b0) begin
        bad++;
        $display("FAIL stall_no_commit%0d: got write=%0b want 0", k, s_write);
      end
    end
    transmit_from_issue = 1'b0;
    total++;
    if (rob_pos_to_issue !== m_tail) begin
      bad++;
      $display("FAIL stall_tail: got %0d want %0d", rob_pos_to_issue, m_tail);
    end
    rdy_in = 1'b1;
    tick();
    total++;
    if (s_write !== 1'b0) begin
      bad++;
      $display("FAIL stall_resume_early: got write=%0b want 0", s_write);
    end
    tick();
    total++;
    if ({s_write, s_pos} !== {1'b1, base}) begin
      bad++;
      $display("FAIL stall_resume_commit: got write=%0b pos=%0d want 1 %0d", s_write, s_pos, base);
    end
  endtask

  initial begin
    rdy_in               = 1'b1;
    transmit_from_issue  = 1'b0;
    rd_from_issue        = '0;
    is_branch_from_issue = 1'b0;
    cdb_valid_in         = 1'b0;
    cdb_rob_pos_in       = '0;
    cdb_data_in          = '0;
    cdb_mispredict_in    = 1'b0;
    cdb_target_in        = '0;
    m_tail               = '0;
    test_reset();
    test_single_commit();
    test_full_wrap();
    test_out_of_order();
    test_flush();
    test_stall();
    wait_empty(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
